red_pitaya_fads_logger: RTL and testbench

Per-droplet event logger downstream of the FADS sorter. On each single-cycle droplet-evaluated strobe it stores the droplet's width, peak intensity, droplet-id low bits and classification flags into a circular block-RAM buffer. Software reads the buffer and status counters over the system bus, so individual droplets can be histogrammed rather than only aggregated.

---
 rtl/red_pitaya_fads_logger_if.sv | 20 ++
 rtl/red_pitaya_fads_logger.sv | 165 ++++++++++++++++
 tb/tb_red_pitaya_fads_logger.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_fads_logger_if.sv
// System-bus bundle between the CPU bridge (master) and the FADS event logger (slave).
interface red_pitaya_fads_logger_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );
  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_fads_logger.sv
// Per-droplet event logger: circular BRAM of droplet records plus status counters on the system bus.
// Define FADS_LOGGER_TIMESTAMP_EN to store a free-running cycle timestamp in word2 of each entry.
module red_pitaya_fads_logger #(
  parameter int AW  = 10,
  parameter int DWT = 14
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rst_i,
  input  logic                  evt_valid_i,
  input  logic [31:0]           evt_id_i,
  input  logic signed [DWT-1:0] evt_intensity_i,
  input  logic [31:0]           evt_width_i,
  input  logic [1:0]            evt_flags_i,
  red_pitaya_fads_logger_if.slave sys
);

`ifdef FADS_LOGGER_TIMESTAMP_EN
  localparam int MW = 96;
`else
  localparam int MW = 64;
`endif
  localparam int DEPTH = 1 << AW;

  logic          r_enable;
  logic          r_stop;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_dropped;
  logic [31:0]   r_accepted;
  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] r_ram_q;
  logic          r_buf_pend1;
  logic          r_buf_pend2;
  logic [AW-1:0] r_rd_idx;
  logic [1:0]    r_rd_word1;
  logic [1:0]    r_rd_word2;
  logic          r_ack;
  logic [31:0]   r_rdata;

  logic [19:0]        w_addr;
  logic               w_buf_hit;
  logic               w_ctrl_wr;
  logic               w_clear;
  logic               w_full;
  logic               w_evt;
  logic               w_drop;
  logic               w_we;
  logic signed [13:0] w_int14;
  logic [MW-1:0]      w_entry;
  logic [31:0]        w_reg_rdata;
  logic [31:0]        w_buf_rdata;
  logic               w_unused;

  assign w_addr    = sys.sys_addr[19:0];
  // Buffer window starts at 0x10000 and spans 2^(AW+4) bytes; 0x10000 is aligned to that for AW<=12.
  assign w_buf_hit = (w_addr >> (AW + 4)) == (20'h10000 >> (AW + 4));
  assign w_ctrl_wr = sys.sys_wen && (w_addr == 20'h00000);
  assign w_clear   = w_ctrl_wr && sys.sys_wdata[2];
  assign w_full    = r_count[AW];
  assign w_evt     = evt_valid_i && r_enable && !w_clear;
  assign w_drop    = w_evt && w_full && r_stop;
  assign w_we      = w_evt && !(w_full && r_stop);
  assign w_int14   = 14'(evt_intensity_i);
  assign w_unused  = ^{sys.sys_addr[31:20], sys.sys_sel, sys.sys_wdata[31:3], evt_id_i[31:16]};

`ifdef FADS_LOGGER_TIMESTAMP_EN
  logic [31:0] r_ts;

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) r_ts <= 32'd0;
    else           r_ts <= r_ts + 32'd1;
  end

  assign w_entry = {r_ts, evt_id_i[15:0], evt_flags_i, w_int14, evt_width_i};
`else
  assign w_entry = {evt_id_i[15:0], evt_flags_i, w_int14, evt_width_i};
`endif

  // Clear has priority over a same-cycle event so the event is neither stored nor counted as dropped.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_enable   <= 1'b1;
      r_stop     <= 1'b0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_dropped  <= 32'd0;
      r_accepted <= 32'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= sys.sys_wdata[0];
        r_stop   <= sys.sys_wdata[1];
      end
      if (w_clear) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_dropped  <= 32'd0;
        r_accepted <= 32'd0;
      end else begin
        if (w_we) begin
          r_wr_ptr   <= r_wr_ptr + AW'(1);
          r_accepted <= r_accepted + 32'd1;
          if (!w_full) r_count <= r_count + (AW+1)'(1);
        end
        if (w_drop && (r_dropped != 32'hFFFF_FFFF)) r_dropped <= r_dropped + 32'd1;
      end
    end
  end

  // Read-first BRAM: no reset so it maps onto block RAM.
  always_ff @(posedge adc_clk_i) begin
    if (w_we) r_mem[r_wr_ptr] <= w_entry;
    r_ram_q <= r_mem[r_rd_idx];
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_buf_pend1 <= 1'b0;
      r_buf_pend2 <= 1'b0;
      r_rd_idx    <= '0;
      r_rd_word1  <= 2'd0;
      r_rd_word2  <= 2'd0;
      r_ack       <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_buf_pend1 <= sys.sys_ren && w_buf_hit;
      r_buf_pend2 <= r_buf_pend1;
      r_rd_word2  <= r_rd_word1;
      if (sys.sys_ren && w_buf_hit) begin
        r_rd_idx   <= w_addr[AW+3:4];
        r_rd_word1 <= w_addr[3:2];
      end
      r_ack   <= sys.sys_wen || (sys.sys_ren && !w_buf_hit);
      r_rdata <= (sys.sys_ren && !w_buf_hit) ? w_reg_rdata : 32'd0;
    end
  end

  always_comb begin
    w_reg_rdata = 32'd0;
    case (w_addr)
      20'h00000: w_reg_rdata = {30'd0, r_stop, r_enable};
      20'h00004: w_reg_rdata = 32'(r_wr_ptr);
      20'h00008: w_reg_rdata = 32'(r_count);
      20'h0000C: w_reg_rdata = r_dropped;
      20'h00010: w_reg_rdata = r_accepted;
      default:   w_reg_rdata = 32'd0;
    endcase
  end

  always_comb begin
    w_buf_rdata = 32'd0;
    case (r_rd_word2)
      2'd0:    w_buf_rdata = r_ram_q[31:0];
      2'd1:    w_buf_rdata = r_ram_q[63:32];
`ifdef FADS_LOGGER_TIMESTAMP_EN
      2'd2:    w_buf_rdata = r_ram_q[95:64];
`endif
      default: w_buf_rdata = 32'd0;
    endcase
  end

  assign sys.sys_rdata = r_buf_pend2 ? w_buf_rdata : r_rdata;
  assign sys.sys_ack   = r_ack || r_buf_pend2;
  assign sys.sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_fads_logger.sv
// Directed self-checking bench for red_pitaya_fads_logger (AW=4 so wrap and stop cases stay short).
module tb_red_pitaya_fads_logger;

  logic               clk;
  logic               rst;
  logic               evtValid;
  logic [31:0]        evtId;
  logic signed [13:0] evtIntensity;
  logic [31:0]        evtWidth;
  logic [1:0]         evtFlags;
  int                 compareCount;
  int                 mismatchCount;
  logic [31:0]        rd;
  logic [31:0]        ts0;
  logic [31:0]        ts1;

  red_pitaya_fads_logger_if bus ();

  red_pitaya_fads_logger #(.AW(4), .DWT(14)) dut (
    .adc_clk_i      (clk),
    .adc_rst_i      (rst),
    .evt_valid_i    (evtValid),
    .evt_id_i       (evtId),
    .evt_intensity_i(evtIntensity),
    .evt_width_i    (evtWidth),
    .evt_flags_i    (evtFlags),
    .sys            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] id, input logic signed [13:0] intensity,
                               input logic [31:0] width, input logic [1:0] flags);
    @(negedge clk);
    evtValid = 1'b1; evtId = id; evtIntensity = intensity; evtWidth = width; evtFlags = flags;
    @(negedge clk);
    evtValid = 1'b0;
  endtask

  task automatic busWrite(input logic [19:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.sys_addr = {12'd0, addr}; bus.sys_wdata = data; bus.sys_wen = 1'b1;
    @(negedge clk);
    bus.sys_wen = 1'b0;
    checkOutput("wrAck", {31'd0, bus.sys_ack}, 32'd1);
  endtask

  task automatic regRead(input logic [19:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.sys_addr = {12'd0, addr}; bus.sys_ren = 1'b1;
    @(negedge clk);
    bus.sys_ren = 1'b0;
    checkOutput("rdAck", {31'd0, bus.sys_ack}, 32'd1);
    data = bus.sys_rdata;
  endtask

  // Buffer reads must not ack one cycle after the request, only two.
  task automatic bufRead(input int entry, input int word, output logic [31:0] data);
    @(negedge clk);
    bus.sys_addr = 32'h10000 + 32'(entry * 16) + 32'(word * 4); bus.sys_ren = 1'b1;
    @(negedge clk);
    bus.sys_ren = 1'b0;
    checkOutput("bufAckEarly", {31'd0, bus.sys_ack}, 32'd0);
    @(negedge clk);
    checkOutput("bufAck", {31'd0, bus.sys_ack}, 32'd1);
    data = bus.sys_rdata;
  endtask

  task automatic checkCounters(input logic [31:0] ptr, input logic [31:0] cnt,
                               input logic [31:0] drp, input logic [31:0] acc);
    logic [31:0] v;
    regRead(20'h04, v); checkOutput("wrPtr", v, ptr);
    regRead(20'h08, v); checkOutput("count", v, cnt);
    regRead(20'h0C, v); checkOutput("dropped", v, drp);
    regRead(20'h10, v); checkOutput("accepted", v, acc);
  endtask

  initial begin
    compareCount = 0; mismatchCount = 0;
    rst = 1'b1; evtValid = 1'b0; evtId = 32'd0; evtIntensity = 14'sd0; evtWidth = 32'd0; evtFlags = 2'b00;
    bus.sys_addr = 32'd0; bus.sys_wdata = 32'd0; bus.sys_sel = 4'hF; bus.sys_wen = 1'b0; bus.sys_ren = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstAck", {31'd0, bus.sys_ack}, 32'd0);
    checkOutput("rstErr", {31'd0, bus.sys_err}, 32'd0);
    checkOutput("rstRdata", bus.sys_rdata, 32'd0);
    rst = 1'b0;
    regRead(20'h00, rd); checkOutput("rstCtrl", rd, 32'd1);
    checkCounters(0, 0, 0, 0);

    $display("[TB] basic capture");
    applyStimulus(32'h0001_2345, -14'sd5, 32'd300, 2'b01);
    bufRead(0, 0, rd); checkOutput("basicWord0", rd, 32'd300);
    bufRead(0, 1, rd); checkOutput("basicWord1", rd, 32'h2345_7FFB);
    bufRead(0, 3, rd); checkOutput("basicWord3", rd, 32'd0);
    checkCounters(1, 1, 0, 1);
    regRead(20'h14, rd); checkOutput("unmapped", rd, 32'd0);

    $display("[TB] clear with simultaneous event");
    @(negedge clk);
    bus.sys_addr = 32'd0; bus.sys_wdata = 32'h5; bus.sys_wen = 1'b1;
    evtValid = 1'b1; evtWidth = 32'd777; evtId = 32'd9; evtFlags = 2'b10;
    @(negedge clk);
    bus.sys_wen = 1'b0; evtValid = 1'b0;
    checkOutput("clrAck", {31'd0, bus.sys_ack}, 32'd1);
    checkCounters(0, 0, 0, 0);
    bufRead(0, 0, rd); checkOutput("clrKeepsData", rd, 32'd300);

    $display("[TB] disabled events");
    busWrite(20'h00, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(32'd50, 14'sd1, 32'd50, 2'b11);
    checkCounters(0, 0, 0, 0);
    busWrite(20'h00, 32'h1);
    regRead(20'h00, rd); checkOutput("reEnable", rd, 32'd1);

    $display("[TB] wrap-around");
    for (int i = 1; i <= 20; i++) applyStimulus(32'(i), 14'sd100, 32'(i), 2'b00);
    checkCounters(4, 16, 0, 20);
    bufRead(4, 0, rd); checkOutput("wrapOldest", rd, 32'd5);
    bufRead(3, 0, rd); checkOutput("wrapNewest", rd, 32'd20);

    $display("[TB] stop when full");
    busWrite(20'h00, 32'h7);
    regRead(20'h00, rd); checkOutput("stopCtrl", rd, 32'd3);
    for (int i = 1; i <= 20; i++) applyStimulus(32'(i), -14'sd100, 32'(i), 2'b01);
    checkCounters(0, 16, 4, 16);
    bufRead(0, 0, rd); checkOutput("stopEntry0", rd, 32'd1);
    bufRead(15, 0, rd); checkOutput("stopEntry15", rd, 32'd16);

    $display("[TB] reset with a pending buffer read");
    applyStimulus(32'h77, 14'sd10, 32'd55, 2'b10);
    @(negedge clk);
    bus.sys_addr = 32'h10000; bus.sys_ren = 1'b1;
    @(negedge clk);
    bus.sys_ren = 1'b0; rst = 1'b1;
    checkOutput("midAck1", {31'd0, bus.sys_ack}, 32'd0);
    @(negedge clk);
    checkOutput("midAck2", {31'd0, bus.sys_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midAck3", {31'd0, bus.sys_ack}, 32'd0);
    regRead(20'h00, rd); checkOutput("midCtrl", rd, 32'd1);
    checkCounters(0, 0, 0, 0);

    $display("[TB] timestamp");
    applyStimulus(32'h100, 14'sd7, 32'd1000, 2'b01);
    repeat (148) @(negedge clk);
    applyStimulus(32'h101, 14'sd8, 32'd1001, 2'b01);
    bufRead(0, 2, ts0);
    bufRead(1, 2, ts1);
    bufRead(1, 0, rd); checkOutput("tsEntry1", rd, 32'd1001);
`ifdef FADS_LOGGER_TIMESTAMP_EN
    checkOutput("tsDelta", ts1 - ts0, 32'd150);
`else
    checkOutput("tsWord2a", ts0, 32'd0);
    checkOutput("tsWord2b", ts1, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
